// File: rtl/quadrature_generator.sv
// quadrature_generator: steps a/b quadrature outputs toward a loaded target at a programmable edge rate
module quadrature_generator #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     target,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 a,
  output logic                 b,
  output logic [WIDTH-1:0]     position,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, EDGE1, EDGE2} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tgt_q, pos_q, pos_d, diff, pos_step;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, reload;
  logic                 a_q, a_d, b_q, b_d, dn_q, dn_d, done_q, done_d;
  assign reload   = (period == '0) ? '0 : period - DIV_WIDTH'(1);
  assign diff     = tgt_q - pos_q;
  assign pos_step = dn_q ? pos_q - WIDTH'(1) : pos_q + WIDTH'(1);
  // Up steps lead with a, down steps lead with b; position moves on the leading edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    a_d     = a_q;
    b_d     = b_q;
    dn_d    = dn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (diff != '0) begin
        dn_d    = diff[WIDTH-1];
        cnt_d   = reload;
        state_d = EDGE1;
      end
      EDGE1: if (cnt_q != '0) cnt_d = cnt_q - DIV_WIDTH'(1);
      else begin
        a_d     = a_q ^ ~dn_q;
        b_d     = b_q ^ dn_q;
        pos_d   = pos_step;
        cnt_d   = reload;
        state_d = EDGE2;
      end
      EDGE2: if (cnt_q != '0) cnt_d = cnt_q - DIV_WIDTH'(1);
      else begin
        a_d = a_q ^ dn_q;
        b_d = b_q ^ ~dn_q;
        if (diff != '0) begin
          dn_d    = diff[WIDTH-1];
          cnt_d   = reload;
          state_d = EDGE1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      dn_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= load ? target : tgt_q;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dn_q    <= dn_d;
      done_q  <= done_d;
    end
  end
  assign a        = a_q;
  assign b        = b_q;
  assign position = pos_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
endmodule

// File: doc/quadrature_generator.md
Name: quadrature_generator

Overview:
Synthesises a two-phase quadrature signal pair (a, b) that walks a tracked position toward a programmed target, one count per step, at a programmable edge rate. It is the transmit-side counterpart of the team's quadrature decoder and is used to emulate a rotary encoder for on-chip self-test and for driving the decoder in simulation. Edge encoding is chosen so that the decoder, fed a/b directly, counts exactly the same position value.

Parameters:
WIDTH, 8, width of target and position counters (modular arithmetic).
DIV_WIDTH, 16, width of the edge-period input.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous reset, active-low.
target  input  WIDTH  new target position, sampled when load=1.
load  input  1  one-cycle strobe that captures target into the internal target register.
period  input  DIV_WIDTH  clocks between consecutive quadrature edges; sampled each time an edge wait starts.
a  output  1  quadrature phase A, registered.
b  output  1  quadrature phase B, registered.
position  output  WIDTH  count already signalled on a/b, registered.
busy  output  1  high while a step is in progress (state != IDLE).
done  output  1  one-cycle pulse when motion ends with position == target.

Behaviour:
- Reset (reset_n=0 at a clk edge): a=0, b=0, position=0, target register=0, counter=0, busy=0, done=0, state=IDLE. Applies mid-step; the step is abandoned with no done pulse.
- Target register: load=1 updates it on the next edge. load is legal in any state. A step already in progress always completes. The new value is used at the next step decision.
- P = period, with 0 treated as 1. Every edge wait lasts exactly P clocks.
- Direction: diff = (target_reg - position) mod 2^WIDTH. diff==0 means no motion. diff MSB=0 steps up. diff MSB=1 steps down, so exactly half-range goes down.
- States: IDLE, EDGE1, EDGE2.
  - IDLE: if diff != 0, latch direction, counter <= P-1, go to EDGE1. Otherwise stay.
  - EDGE1: counter decrements while nonzero. At 0: toggle the first signal, update position (+1 up, -1 down, wrapping), counter <= P-1, go to EDGE2.
  - EDGE2: at counter 0, toggle the second signal. If the updated diff != 0, re-latch direction, counter <= P-1, go to EDGE1 with no idle gap. Otherwise go to IDLE and pulse done.
- Edge order: up toggles a first, then b. Down toggles b first, then a.
- Rest phase: (a,b) is always 00 or 11 in IDLE. The decoder count changes on the first edge of each step, simultaneous with the position update.
- Step timing: the first edge is P clocks after leaving IDLE. Steady-state step period is 2P clocks. The second edge is P clocks after the first.
- Direction may reverse between steps, never within a step.
- done does not pulse when load sets a target equal to an idle position.
- busy is high from the first EDGE1 cycle to the last EDGE2 cycle inclusive.

Test Plan:
- Reset, then load target=3, period=4 -> (a,b) goes 00,10,11,01,00,10,11 with edges 4 clocks apart; position goes 1,2,3 on the a edges; one done pulse; busy drops; a decoder on a/b reads 3.
- From position 3 at phase 11, load target=1 -> (a,b) goes 10,00,01,11 (b edge first each step); position goes 2,1; done once; decoder reads 1.
- From 0, load target=255 (WIDTH=8) -> one down step (b toggles first), position=255. From 0, load target=128 -> 128 down steps ending at position=128.
- Mid-step retarget: moving up to 10, load target=2 during EDGE2 while position=5 -> current step completes, next step is down, position settles at 2, single done.
- period=0 -> edges on consecutive clocks, step period 2 clocks. Change period mid-motion from 4 to 8 -> the next edge wait uses 8.
- reset_n low during EDGE1 -> next cycle a=b=0, position=0, busy=0, done never pulses, target register=0.
